// File: rtl/primer_pkg.sv
// Shared definitions for the primer prime-sum engine.
// Optional build macro PRIMER_ODD_SKIP_EN is consumed by primer and primer_trial_step.
package primer_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    DONE   = 1'b1
  } state_t;

endpackage

// File: rtl/primer_trial_step.sv
// Combinational single-divisor trial for one (cand, div) pair of the primer engine.
// With PRIMER_ODD_SKIP_EN defined, divisors advance 2, 3, 5, 7, ... instead of by one.
module primer_trial_step
  import primer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] cand,
  input  logic [WIDTH-1:0] div,
  output logic             is_prime_now,
  output logic             is_composite,
  output logic [WIDTH-1:0] next_div
);

  logic [2*WIDTH-1:0] div_sq;
  logic [WIDTH-1:0]   rem;
  logic               below_two;

  always_comb begin
    // Square in double width so large divisors cannot wrap and fake a prime.
    div_sq       = {{WIDTH{1'b0}}, div} * {{WIDTH{1'b0}}, div};
    rem          = cand % div;
    below_two    = cand < WIDTH'(2);
    is_prime_now = !below_two && (div_sq > {{WIDTH{1'b0}}, cand});
    is_composite = below_two || (rem == '0);
`ifdef PRIMER_ODD_SKIP_EN
    next_div     = (div == WIDTH'(2)) ? WIDTH'(3) : div + WIDTH'(2);
`else
    next_div     = div + WIDTH'(1);
`endif
  end

endmodule

// File: rtl/primer.sv
// Prime-sum engine: sums the first N primes >= A by trial division, one divisor per cycle.
// Optional macro PRIMER_ODD_SKIP_EN skips even candidates above 2 and even divisors above 2.
module primer
  import primer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] prime,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] prime_q, prime_d;

  logic             is_prime_now;
  logic             is_composite;
  logic [WIDTH-1:0] next_div;
  logic [WIDTH-1:0] cand_plus1;
  logic [WIDTH-1:0] cand_next;
  logic             at_limit;

  primer_trial_step #(.WIDTH(WIDTH)) u_trial_step (
    .cand        (cand_q),
    .div         (div_q),
    .is_prime_now(is_prime_now),
    .is_composite(is_composite),
    .next_div    (next_div)
  );

  always_comb begin
    cand_plus1 = cand_q + WIDTH'(1);
    at_limit   = (cand_q == '1);
`ifdef PRIMER_ODD_SKIP_EN
    cand_next  = (!cand_plus1[0] && (cand_plus1 > WIDTH'(2))) ? cand_q + WIDTH'(2) : cand_plus1;
`else
    cand_next  = cand_plus1;
`endif
  end

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    div_d       = div_q;
    remaining_d = remaining_q;
    sum_d       = sum_q;
    prime_d     = prime_q;
    if (state_q == SEARCH) begin
      // Prime test takes priority: cand=2, div=2 divides evenly but is prime.
      if (is_prime_now) begin
        sum_d       = sum_q + cand_q;
        prime_d     = cand_q;
        remaining_d = remaining_q - WIDTH'(1);
        cand_d      = cand_next;
        div_d       = WIDTH'(2);
        if ((remaining_q == WIDTH'(1)) || at_limit) state_d = DONE;
      end else if (is_composite) begin
        cand_d = cand_next;
        div_d  = WIDTH'(2);
        if (at_limit) state_d = DONE;
      end else begin
        div_d = next_div;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= (N == '0) ? DONE : SEARCH;
      cand_q      <= A;
      div_q       <= WIDTH'(2);
      remaining_q <= N;
      sum_q       <= '0;
      prime_q     <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      div_q       <= div_d;
      remaining_q <= remaining_d;
      sum_q       <= sum_d;
      prime_q     <= prime_d;
    end
  end

  assign sum   = sum_q;
  assign prime = prime_q;
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_primer.sv
// Self-checking bench for primer: directed and random (A, N) runs against a
// trial-division reference that lists the first N primes >= A.
module tb_primer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] A = '0;
  logic [31:0] N = '0;
  logic [31:0] sum;
  logic [31:0] prime;
  logic        done;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_sums[$];
  logic [31:0] exp_primes[$];

  primer #(.WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .A    (A),
    .N    (N),
    .sum  (sum),
    .prime(prime),
    .done (done)
  );

  always #5 clk = ~clk;

  function automatic bit is_prime(input longint unsigned c);
    if (c < 2) return 1'b0;
    for (longint unsigned d = 2; d * d <= c; d++)
      if (c % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Expected (sum, prime) after each prime found, in order.
  task automatic buildModel(input logic [31:0] a, input logic [31:0] n);
    longint unsigned c = longint'(a);
    logic [31:0] acc = '0;
    exp_sums.delete();
    exp_primes.delete();
    while ((exp_sums.size() < int'(n)) && (c <= 64'hFFFF_FFFF)) begin
      if (is_prime(c)) begin
        acc = acc + c[31:0];
        exp_sums.push_back(acc);
        exp_primes.push_back(c[31:0]);
      end
      c++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One reset cycle with new A/N, then release; checks the post-reset state.
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] n);
    buildModel(a, n);
    @(negedge clk);
    reset = 1'b1;
    A = a;
    N = n;
    @(negedge clk);
    checkOutput({tag, " reset sum"}, sum, 0);
    checkOutput({tag, " reset prime"}, prime, 0);
    checkOutput({tag, " reset done"}, done, (n == 0) ? 1 : 0);
    reset = 1'b0;
    A = $urandom;
    N = $urandom;
  endtask

  task automatic runToDone(input string tag, input int max_cycles);
    int cyc = 0;
    int idx = 0;
    logic [31:0] last_sum = '0;
    logic [31:0] last_prime = '0;
    logic [31:0] final_sum = '0;
    logic [31:0] final_prime = '0;
    while ((done !== 1'b1) && (cyc < max_cycles)) begin
      @(negedge clk);
      cyc++;
      if ((sum !== last_sum) || (prime !== last_prime)) begin
        if (idx < exp_sums.size()) begin
          checkOutput({tag, " step sum"}, sum, exp_sums[idx]);
          checkOutput({tag, " step prime"}, prime, exp_primes[idx]);
        end else begin
          checkOutput({tag, " unexpected update"}, sum, last_sum);
        end
        idx++;
        last_sum = sum;
        last_prime = prime;
      end
    end
    if (exp_sums.size() > 0) begin
      final_sum = exp_sums[exp_sums.size()-1];
      final_prime = exp_primes[exp_primes.size()-1];
    end
    checkOutput({tag, " done within budget"}, done, 1);
    checkOutput({tag, " update count"}, idx, exp_sums.size());
    checkOutput({tag, " final sum"}, sum, final_sum);
    checkOutput({tag, " final prime"}, prime, final_prime);
    repeat (3) @(negedge clk);
    checkOutput({tag, " hold sum"}, sum, final_sum);
    checkOutput({tag, " hold prime"}, prime, final_prime);
    checkOutput({tag, " hold done"}, done, 1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rn;

    applyStimulus("A3N4", 32'd3, 32'd4);
    runToDone("A3N4", 20);

    applyStimulus("A0N3", 32'd0, 32'd3);
    runToDone("A0N3", 200);

    applyStimulus("A14N1", 32'd14, 32'd1);
    runToDone("A14N1", 200);

    applyStimulus("N0", 32'd57, 32'd0);
    @(negedge clk);
    checkOutput("N0 first cycle done", done, 1);
    runToDone("N0", 5);

    applyStimulus("midA3N4", 32'd3, 32'd4);
    repeat (5) @(negedge clk);
    applyStimulus("midA20N2", 32'd20, 32'd2);
    runToDone("midA20N2", 200);

    applyStimulus("limit", 32'hFFFF_FFFE, 32'd5);
    runToDone("limit", 50);

    for (int i = 0; i < 10; i++) begin
      ra = $urandom_range(0, 300);
      rn = $urandom_range(0, 6);
      $display("[TB] random run %0d: A=%0d N=%0d", i, ra, rn);
      applyStimulus("rand", ra, rn);
      runToDone("rand", 3000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
